cla_adder_pipe_32: RTL and testbench

- 32-bit two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
- Stage 1 forms nibble-level block propagate/generate (p, g) for eight 4-bit groups.
- Stage 2 consumes those p/g pairs through a two-level lookahead carry network, then forms the sum and the flags.
- Sits between the ALU operand mux (upstream) and the ALU result/flag writeback (downstream).

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_adder_pipe_32_if.sv | 29 ++
 rtl/lcu_4.sv | 21 ++
 rtl/cla_adder_pipe_32.sv | 149 ++++++++++++++
 tb/tb_cla_adder_pipe_32.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared widths and nibble-level propagate/generate helpers for the pipelined
// carry-lookahead adder.
package cla_pkg;

    localparam int WIDTH = 32;
    localparam int NIB   = 4;

    typedef struct packed {
        logic p;
        logic g;
    } nib_pg_t;

    // Block propagate/generate of one 4-bit group; g ignores the group carry-in
    function automatic nib_pg_t nibble_pg(input logic [NIB-1:0] a, input logic [NIB-1:0] b);
        logic [NIB-1:0] pb;
        logic [NIB-1:0] gb;
        nib_pg_t        r;
        pb  = a ^ b;
        gb  = a & b;
        r.p = &pb;
        r.g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_32_if.sv
// Operand/result handshake bundle between the ALU operand mux, the adder and
// the result/flag writeback.
interface cla_adder_pipe_32_if;
    import cla_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in1, in2, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, in1, in2, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );

endinterface

// File: rtl/lcu_4.sv
// Four-group lookahead carry unit: carries out of each group plus the block
// propagate/generate of all four, usable at bit or group granularity.
module lcu_4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [4:1] c,
    output logic       blk_p,
    output logic       blk_g
);

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign blk_p = &p;
    assign blk_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder_pipe_32.sv
// Two-stage pipelined 32-bit carry-lookahead adder/subtractor: stage 1 registers
// per-bit and per-nibble P/G, stage 2 resolves carries and registers sum and flags.
module cla_adder_pipe_32
    import cla_pkg::*;
#(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_adder_pipe_32_if.slave   bus
);

    logic                      en1_s;
    logic                      en2_s;
    logic                      v1_r;
    logic                      v2_r;

    logic [WIDTH-1:0]          beff_s;
    logic                      cin_eff_s;
    nib_pg_t [NIBBLES-1:0]     nib_pg_s;

    logic [WIDTH-1:0]          pbit_r;
    logic [WIDTH-1:0]          gbit_r;
    logic                      cin_r;
    nib_pg_t [NIBBLES-1:0]     nib_pg_r;

    logic [NIBBLES-1:0]        blk_p_s;
    logic [NIBBLES-1:0]        blk_g_s;
    logic [4:1]                lo_c_s;
    logic [4:1]                hi_c_s;
    logic                      lo_p_s;
    logic                      lo_g_s;
    logic                      hi_p_s;
    logic                      hi_g_s;
    logic [NIBBLES:0]          nib_cin_s;
    logic [NIBBLES-1:0][4:1]   nib_c_s;
    logic [NIBBLES-1:0]        nib_bp_unused_s;
    logic [NIBBLES-1:0]        nib_bg_unused_s;
    logic [NIBBLES-1:0]        nib_c4_unused_s;
    logic [1:0]                grp_c4_unused_s;
    logic [WIDTH-1:0]          carry_s;
    logic [WIDTH-1:0]          sum_s;

    logic [WIDTH-1:0]          sum_r;
    logic                      c_out_r;
    logic                      ovf_r;
    logic                      zero_r;

    assign en2_s        = ~v2_r | bus.out_ready;
    assign en1_s        = ~v1_r | en2_s;
    assign bus.in_ready = en1_s;

    // Subtraction is A + ~B + 1, so the carry-in input is irrelevant then
    assign beff_s    = bus.sub ? ~bus.in2 : bus.in2;
    assign cin_eff_s = bus.sub | bus.c_in;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_pg
        assign nib_pg_s[k] = nibble_pg(bus.in1[NIB*k +: NIB], beff_s[NIB*k +: NIB]);
        assign blk_p_s[k]  = nib_pg_r[k].p;
        assign blk_g_s[k]  = nib_pg_r[k].g;
    end

    // Stage 1: capture per-bit and per-nibble propagate/generate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r     <= 1'b0;
            pbit_r   <= {WIDTH{1'b0}};
            gbit_r   <= {WIDTH{1'b0}};
            cin_r    <= 1'b0;
            nib_pg_r <= {NIBBLES{2'b00}};
        end else if (en1_s) begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                pbit_r   <= bus.in1 ^ beff_s;
                gbit_r   <= bus.in1 & beff_s;
                cin_r    <= cin_eff_s;
                nib_pg_r <= nib_pg_s;
            end
        end
    end

    lcu_4 u_lcu_lo (
        .p     (blk_p_s[3:0]),
        .g     (blk_g_s[3:0]),
        .cin   (cin_r),
        .c     (lo_c_s),
        .blk_p (lo_p_s),
        .blk_g (lo_g_s)
    );

    lcu_4 u_lcu_hi (
        .p     (blk_p_s[7:4]),
        .g     (blk_g_s[7:4]),
        .cin   (nib_cin_s[4]),
        .c     (hi_c_s),
        .blk_p (hi_p_s),
        .blk_g (hi_g_s)
    );

    // Level 2 joins the two half-words through their super-group P/G
    assign nib_cin_s[0]   = cin_r;
    assign nib_cin_s[3:1] = lo_c_s[3:1];
    assign nib_cin_s[4]   = lo_g_s | (lo_p_s & cin_r);
    assign nib_cin_s[7:5] = hi_c_s[3:1];
    assign nib_cin_s[8]   = hi_g_s | (hi_p_s & nib_cin_s[4]);
    assign grp_c4_unused_s = {lo_c_s[4], hi_c_s[4]};

    for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
        lcu_4 u_lcu_nib (
            .p     (pbit_r[NIB*k +: NIB]),
            .g     (gbit_r[NIB*k +: NIB]),
            .cin   (nib_cin_s[k]),
            .c     (nib_c_s[k]),
            .blk_p (nib_bp_unused_s[k]),
            .blk_g (nib_bg_unused_s[k])
        );
        assign carry_s[NIB*k]         = nib_cin_s[k];
        assign carry_s[NIB*k+1 +: 3]  = nib_c_s[k][3:1];
        assign nib_c4_unused_s[k]     = nib_c_s[k][4];
    end

    assign sum_s = pbit_r ^ carry_s;

    // Stage 2: result and flags; bubbles keep the previous result in place
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_r    <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                sum_r   <= sum_s;
                c_out_r <= nib_cin_s[NIBBLES];
                ovf_r   <= carry_s[WIDTH-1] ^ nib_cin_s[NIBBLES];
                zero_r  <= ~|sum_s;
            end
        end
    end

    assign bus.out_valid = v2_r;
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_cla_adder_pipe_32.sv
// Scoreboard bench for cla_adder_pipe_32: transfers are modelled with plain
// integer arithmetic and checked in order by an independent monitor.
module tb_cla_adder_pipe_32;

    typedef struct {
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    cla_adder_pipe_32_if bus ();

    cla_adder_pipe_32 #(.NIBBLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   pop_cyc_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   accepted  = 0;
    bit   lat_check = 1'b0;
    bit   hold_valid = 1'b0;
    logic [34:0] hold_val;
    exp_t mon_e;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic s);
        exp_t        r;
        logic [31:0] beff;
        logic        cin_e;
        logic [63:0] u;
        longint      sv;
        beff  = s ? ~b : b;
        cin_e = s ? 1'b1 : ci;
        u     = {32'd0, a} + {32'd0, beff} + {63'd0, cin_e};
        sv    = longint'($signed(a)) + longint'($signed(beff)) + longint'(cin_e);
        r.sum   = u[31:0];
        r.c_out = u[32];
        r.ovf   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        r.zero  = (u[31:0] == 32'd0);
        r.cyc   = 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: push on input transfer, pop/compare on output transfer, check hold
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid)
                check("hold_stable", 64'({bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero}),
                      64'({1'b1, hold_val}));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h expected=none", bus.sum);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", 64'({bus.sum, bus.c_out, bus.ovf, bus.zero}),
                          64'({mon_e.sum, mon_e.c_out, mon_e.ovf, mon_e.zero}));
                    if (lat_check)
                        check("latency", 64'(cyc - mon_e.cyc), 64'(2));
                    pop_cyc_q.push_back(cyc);
                end
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            hold_val   = {bus.sum, bus.c_out, bus.ovf, bus.zero};
            if (bus.in_valid && bus.in_ready) begin
                mon_e     = model(bus.in1, bus.in2, bus.c_in, bus.sub);
                mon_e.cyc = cyc;
                sb_q.push_back(mon_e);
                accepted++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
        bit got;
        got          = 1'b0;
        bus.in1      = a;
        bus.in2      = b;
        bus.c_in     = ci;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept expected=accept a=0x%0h", a);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int target;
        int guard;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = 32'd0;
        bus.in2       = 32'd0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        wait_cycles(2);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_flags", 64'({bus.c_out, bus.ovf, bus.zero}), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        wait_cycles(1);

        // Full ripple, signed overflow, subtraction corners (latency checked)
        lat_check = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_cycles(3);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_cycles(3);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 1'b1);
        wait_cycles(4);

        // Back-to-back stream with no bubbles
        pop_cyc_q.delete();
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_cycles(4);
        check("burst_count", 64'(pop_cyc_q.size()), 64'(4));
        for (int i = 1; i < 4 && i < pop_cyc_q.size(); i++)
            check("no_bubble", 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'(1));
        lat_check = 1'b0;

        // Backpressure: two accepted, third stalls until downstream frees
        bus.out_ready = 1'b0;
        send(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
        send(32'h0000_2000, 32'h0000_0001, 1'b1, 1'b0);
        bus.in1      = 32'h0000_3000;
        bus.in2      = 32'h0000_0003;
        bus.c_in     = 1'b0;
        bus.sub      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(32'h0000_3000, 32'h0000_0003, 1'b0, 1'b1);
        wait_cycles(5);
        check("bp_drained", 64'(sb_q.size()), 64'(0));

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_sum", 64'(bus.sum), 64'(0));
        check("mid_rst_flags", 64'({bus.c_out, bus.ovf, bus.zero}), 64'(0));
        sb_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("no_stale_result", 64'(bus.out_valid), 64'(0));
            @(negedge clk);
        end
        wait_cycles(1);

        // Randomised traffic under random valid/ready
        target = accepted + 10000;
        guard  = 0;
        while (accepted < target && guard < 60000) begin
            @(posedge clk);
            #1;
            guard++;
            bus.in1       = rand_word();
            bus.in2       = rand_word();
            bus.c_in      = 1'($urandom_range(0, 1));
            bus.sub       = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (accepted < target) begin
            checks++;
            failures++;
            $display("FAIL random_budget actual=%0d expected=%0d", accepted, target);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++)
            wait_cycles(1);
        wait_cycles(2);
        check("final_drain", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
